// File: rtl/sll_rol_seq_if.sv
// Operand/result handshake bundle for the multi-cycle left shifter.
interface sll_rol_seq_if #(
  parameter int unsigned WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;

  // Producer of operands / consumer of results
  modport master (
    output in_valid,
    output A,
    output B,
    output Sel,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  Result
  );

  // The shifter itself
  modport slave (
    input  in_valid,
    input  A,
    input  B,
    input  Sel,
    input  out_ready,
    output in_ready,
    output out_valid,
    output Result
  );

endinterface

// File: rtl/sll_rol_seq.sv
// Multi-cycle logical-shift-left / rotate-left unit: one log-shifter stage
// per cycle, MSB stage first, fixed latency regardless of shift amount.
module sll_rol_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic         clk,
  input  logic         rst,
  sll_rol_seq_if.slave bus
);

  // Elaboration-time guard on the parameter relationship
  if (WIDTH != (32'd1 << SHW)) begin : g_param_check
    $error("sll_rol_seq: WIDTH must equal 2**SHW");
  end

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state,     state_d;
  logic [WIDTH-1:0] acc,       acc_d;
  logic [SHW-1:0]   amt,       amt_d;
  logic             mode,      mode_d;
  logic [SHW-1:0]   k,         k_d;
  logic [WIDTH-1:0] result_q,  result_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  // Upper shift-amount bits are architecturally ignored
  logic unused_b_hi;
  assign unused_b_hi = ^bus.B[WIDTH-1:SHW];

  // One shifter stage: shift/rotate left by 2**stage
  function automatic logic [WIDTH-1:0] stage_shift(
    input logic [WIDTH-1:0] v,
    input logic [SHW-1:0]   stage,
    input logic             rot
  );
    logic [WIDTH-1:0] r;
    r = v;
    for (int i = 0; i < int'(SHW); i++) begin
      if (stage == SHW'(i)) begin
        if (rot) r = (v << (1 << i)) | (v >> (int'(WIDTH) - (1 << i)));
        else     r = v << (1 << i);
      end
    end
    return r;
  endfunction

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d     = state;
    acc_d       = acc;
    amt_d       = amt;
    mode_d      = mode;
    k_d         = k;
    result_d    = result_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.in_valid) begin
          acc_d   = bus.A;
          amt_d   = bus.B[SHW-1:0];
          mode_d  = bus.Sel;
          k_d     = SHW'(SHW - 1);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (amt[k]) acc_d = stage_shift(acc, k, mode);
        if (k == '0) begin
          result_d = acc_d;
          state_d  = S_DONE;
        end else begin
          k_d = k - SHW'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      acc         <= '0;
      amt         <= '0;
      mode        <= 1'b0;
      k           <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_d;
      acc         <= acc_d;
      amt         <= amt_d;
      mode        <= mode_d;
      k           <= k_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Result    = result_q;

endmodule

// File: tb/tb_sll_rol_seq.sv
// Directed, table-driven bench for sll_rol_seq.
module tb_sll_rol_seq;

  logic clk;
  logic rst;

  sll_rol_seq_if #(.WIDTH(32)) bus ();

  sll_rol_seq #(.WIDTH(32), .SHW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sel;
    logic [31:0] exp;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] got=%h want=%h", name, id, act, exp);
  endtask

  // Full operation with out_ready held high: checks handshake, latency and result
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] exp, input int id);
    int lat;
    bit seen;
    @(negedge clk);
    check("in_ready_idle", id, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.A = a;
    bus.B = b;
    bus.Sel = s;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A = ~a;
    bus.B = 32'h0;
    bus.Sel = ~s;
    check("in_ready_busy", id, 32'(bus.in_ready), 32'd0);
    lat = 0;
    seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        lat = c;
      end
    end
    check("latency", id, 32'(lat), 32'd5);
    check("result", id, bus.Result, exp);
    if (s) check("popcount", id, 32'($countones(bus.Result)), 32'($countones(a)));
    @(negedge clk);
    check("idle_after", id, {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
  endtask

  initial begin
    int acc_cyc [$];
    logic [31:0] res_q [$];
    int cyc;
    bit seen;
    int nacc;

    vecs[0]  = '{32'h0000_0001, 32'd31,        1'b0, 32'h8000_0000};
    vecs[1]  = '{32'h8000_0001, 32'd1,         1'b1, 32'h0000_0003};
    vecs[2]  = '{32'h8000_0001, 32'd1,         1'b0, 32'h0000_0002};
    vecs[3]  = '{32'hFFFF_FFFF, 32'hFFFF_FFE5, 1'b0, 32'hFFFF_FFE0};
    vecs[4]  = '{32'h1234_5678, 32'd0,         1'b1, 32'h1234_5678};
    vecs[5]  = '{32'h1234_5678, 32'd0,         1'b0, 32'h1234_5678};
    vecs[6]  = '{32'h0000_0003, 32'd31,        1'b1, 32'h8000_0001};
    vecs[7]  = '{32'h1234_5678, 32'd4,         1'b1, 32'h2345_6781};
    vecs[8]  = '{32'h1234_5678, 32'd16,        1'b1, 32'h5678_1234};
    vecs[9]  = '{32'hFFFF_FFFF, 32'd31,        1'b0, 32'h8000_0000};
    vecs[10] = '{32'hDEAD_BEEF, 32'd8,         1'b1, 32'hADBE_EFDE};
    vecs[11] = '{32'h0000_F0F0, 32'h0000_002C, 1'b0, 32'h0F0F_0000};

    // Reset with noisy inputs
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.A = 32'hA5A5_A5A5;
    bus.B = 32'd3;
    bus.Sel = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 0, 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 0, 32'(bus.out_valid), 32'd0);
    check("rst_result", 0, bus.Result, 32'h0);
    bus.in_valid = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].exp, i);

    // Backpressure: result held while out_ready is low, new inputs ignored
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A = 32'h0000_00F0;
    bus.B = 32'd4;
    bus.Sel = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("bp_seen", 100, 32'(seen), 32'd1);
    for (int c = 0; c < 3; c++) begin
      bus.in_valid = ~bus.in_valid;
      bus.A = bus.A + 32'h1111_1111;
      @(negedge clk);
      check("bp_result", 100 + c, bus.Result, 32'h0000_0F00);
      check("bp_flags", 100 + c, {30'd0, bus.out_valid, bus.in_ready}, 32'd2);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 103, {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    run_op(32'h0000_0005, 32'd3, 1'b0, 32'h0000_0028, 104);

    // Reset during the second SHIFT cycle aborts the operation
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A = 32'hDEAD_BEEF;
    bus.B = 32'd8;
    bus.Sel = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_flags", 200, {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    check("abort_result", 200, bus.Result, 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("abort_no_valid", 200, 32'(seen), 32'd0);
    run_op(32'h0000_0001, 32'd2, 1'b0, 32'h0000_0004, 201);

    // Back-to-back with in_valid held high through the busy period
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A = 32'h0000_00FF;
    bus.B = 32'd28;
    bus.Sel = 1'b1;
    nacc = 0;
    for (cyc = 0; cyc < 30; cyc++) begin
      if (bus.out_valid && bus.out_ready) res_q.push_back(bus.Result);
      if (bus.in_valid && bus.in_ready) begin
        acc_cyc.push_back(cyc);
        nacc++;
      end
      @(negedge clk);
      if (nacc == 1) begin
        bus.A = 32'h0000_0001;
        bus.B = 32'd5;
        bus.Sel = 1'b0;
      end
      if (nacc >= 2) bus.in_valid = 1'b0;
    end
    check("b2b_accepts", 300, 32'(acc_cyc.size()), 32'd2);
    check("b2b_spacing", 300, (acc_cyc.size() == 2) ? 32'(acc_cyc[1] - acc_cyc[0]) : 32'hFFFF_FFFF, 32'd7);
    check("b2b_nres", 300, 32'(res_q.size()), 32'd2);
    check("b2b_res0", 300, (res_q.size() > 0) ? res_q[0] : 32'hXXXX_XXXX, 32'hF000_000F);
    check("b2b_res1", 301, (res_q.size() > 1) ? res_q[1] : 32'hXXXX_XXXX, 32'h0000_0020);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sll_rol_seq.md
Name: sll_rol_seq

Overview:
- Multi-cycle left shifter for the ALU shift path; the left-direction counterpart of the combined right-shift (logical/arithmetic) unit.
- Performs logical shift left (SLL) or rotate left (ROL) of a WIDTH-bit operand by the low SHW bits of a shift-amount operand.
- Uses one log-shifter stage per cycle, with valid/ready handshakes on input and output.
- Sits beside the right-shift unit; the ALU result mux selects between them.

Parameters:
- WIDTH, 32, operand/result width; must be a power of 2.
- SHW, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  unit can accept operands
- A  input  WIDTH  operand to shift
- B  input  WIDTH  shift amount; only B[SHW-1:0] used, upper bits ignored
- Sel  input  1  0 = SLL (zero fill), 1 = ROL (bits leaving MSB re-enter at LSB)
- out_valid  output  1  Result valid
- out_ready  input  1  consumer accepts Result
- Result  output  WIDTH  shifted/rotated value

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high on clk/rst.
  - rst high at a rising edge forces state=IDLE, in_ready=1, out_valid=0, Result=0, internal stage counter=0.
  - rst overrides all other inputs in that cycle.
- State machine IDLE -> SHIFT -> DONE -> IDLE:
  - IDLE: in_ready=1, out_valid=0. On an edge with in_valid=1:
    - capture acc<=A, amt<=B[SHW-1:0], mode<=Sel, k<=SHW-1;
    - go to SHIFT.
  - SHIFT: in_ready=0, out_valid=0. Each edge:
    - if amt[k]=1, acc<=acc shifted left by 2^k (SLL zero-fills LSBs; ROL wraps the top 2^k bits into the bottom);
    - if amt[k]=0, acc is held;
    - if k=0, go to DONE; else k<=k-1.
  - DONE: in_ready=0, out_valid=1, Result=acc.
    - On an edge with out_ready=1, go to IDLE (out_valid drops the following cycle).
    - While out_ready=0, hold Result and out_valid stable.
- Latency and throughput:
  - Input accepted at edge t0. SHIFT occupies edges t0+1..t0+SHW.
  - out_valid=1 during the cycle after edge t0+SHW, i.e. 5 cycles after acceptance for SHW=5.
  - Latency is fixed and independent of the shift amount; there is no early termination.
  - Maximum throughput is one operation per SHW+2 cycles. No new input is accepted in DONE, even if out_ready=1 in the same cycle.
- Input capture and output hold:
  - A, B and Sel are sampled only at the accepting edge. Later changes on these inputs do not affect the operation in flight.
  - Result keeps its last value after the DONE->IDLE transition; it is only meaningful while out_valid=1.
- Boundary conditions:
  - B[SHW-1:0]=0 gives Result=A, for both SLL and ROL.
  - Maximum amount (31): SLL leaves only A[0] at the MSB, others 0. ROL equals a rotate right by 1.
  - ROL by any amount preserves the popcount of A.
  - in_valid asserted while busy is ignored (not queued); the source holds it until in_ready=1.
  - rst during SHIFT or DONE aborts the operation, discards it, and no out_valid pulse is produced.
- Width rules:
  - All arithmetic on acc is WIDTH bits; no carry-out or overflow flag.
  - The stage counter k is SHW-bit wide (down-counter from SHW-1 to 0).

Test Plan:
- A=0x0000_0001, B=31, Sel=0, in_valid one cycle -> in_ready drops next cycle; out_valid=1 exactly 5 cycles after accept with Result=0x8000_0000; with out_ready=1, IDLE next cycle.
- A=0x8000_0001, B=1, Sel=1 -> Result=0x0000_0003. Same A with B=1, Sel=0 -> Result=0x0000_0002.
- A=0xFFFF_FFFF, B=0xFFFF_FFE5 (low bits =5), Sel=0 -> Result=0xFFFF_FFE0 (upper B bits ignored). A=0x1234_5678, B=0, Sel=1 -> Result=0x1234_5678.
- Backpressure: complete op with A=0x0000_00F0, B=4, Sel=0 and hold out_ready=0 for 3 cycles while toggling in_valid/A -> Result=0x0000_0F00 stable, out_valid=1, in_ready=0 throughout. out_ready=1 -> IDLE, then the next input is accepted.
- Reset mid-op: accept A=0xDEAD_BEEF, B=8; assert rst at the 2nd SHIFT cycle -> next cycle in_ready=1, out_valid=0, Result=0; no out_valid pulse follows. A new op A=0x0000_0001, B=2, Sel=0 -> Result=0x0000_0004.
- Back-to-back: two ops issued as soon as in_ready permits, with out_ready tied 1 -> accepts spaced exactly 7 cycles apart, each result correct, in_valid held during busy not double-accepted.
